// File: rtl/exp_dp.sv
// exp_dp: Maclaurin-series e^x datapath (X, T, E registers, 3-bit counter, 1/(i+1) ROM)
module exp_dp #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] xBus,
  input  logic             ldX,
  input  logic             initT1,
  input  logic             initE1,
  input  logic             ldT,
  input  logic             ldE,
  input  logic             init0,
  input  logic             cntUp,
  input  logic             selXR,
  output logic             cnt8,
  output logic [WIDTH-1:0] result
);
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(longint'(1) << FRAC);
  function automatic logic signed [WIDTH-1:0] rom_val(input int i);
    longint one;
    one = longint'(1) << FRAC;
    return WIDTH'((one + longint'((i + 1) / 2)) / longint'(i + 1));
  endfunction
  logic signed [WIDTH-1:0]   x, t, e, mul_b, t_mul, e_add;
  logic signed [WIDTH-1:0]   rom [8];
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic signed [WIDTH:0]     sum;
  logic [2:0]                cnt;
  logic                      prod_ovf;
  for (genvar i = 0; i < 8; i++) begin : g_rom
    assign rom[i] = rom_val(i);
  end
  // product keeps full 2*WIDTH precision; >>> floors, then clamp if the top bits disagree
  always_comb begin
    mul_b    = selXR ? x : rom[cnt];
    prod     = t * mul_b;
    prod_sh  = prod >>> FRAC;
    prod_ovf = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
    t_mul    = prod_ovf ? (prod_sh[2*WIDTH-1] ? MINV : MAXV) : prod_sh[WIDTH-1:0];
    sum      = e + t;
    e_add    = (sum[WIDTH] != sum[WIDTH-1]) ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      t   <= '0;
      e   <= '0;
      cnt <= '0;
    end else begin
      if (ldX) x <= xBus;
      if (initT1) t <= ONE;
      else if (ldT) t <= t_mul;
      if (initE1) e <= ONE;
      else if (ldE) e <= e_add;
      if (init0) cnt <= '0;
      else if (cntUp) cnt <= cnt + 3'd1;
    end
  end
  assign cnt8   = (cnt == 3'd7);
  assign result = e;
endmodule

// File: tb/tb_exp_dp.sv
// tb_exp_dp: randomized self-checking bench for exp_dp against an integer reference model
module tb_exp_dp;
  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] xBus;
  logic               ldX, initT1, initE1, ldT, ldE, init0, cntUp, selXR;
  logic               cnt8;
  logic signed [15:0] result;
  int checks = 0;
  int failures = 0;
  int mx, mt, me, mc;
  int rom [8] = '{4096, 2048, 1365, 1024, 819, 683, 585, 512};

  exp_dp #(.WIDTH(16), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .xBus(xBus), .ldX(ldX), .initT1(initT1), .initE1(initE1),
    .ldT(ldT), .ldE(ldE), .init0(init0), .cntUp(cntUp), .selXR(selXR),
    .cnt8(cnt8), .result(result)
  );

  always #5 clk = ~clk;

  function automatic int sat(input longint v);
    return (v > 32767) ? 32767 : (v < -32768) ? -32768 : int'(v);
  endfunction

  // real-number product scaled by 1/4096, rounded toward -inf, then clamped
  function automatic int fmul(input int a, input int b);
    longint p, q;
    p = longint'(a) * longint'(b);
    q = p / 4096;
    if (p < 0 && (p % 4096) != 0) q = q - 1;
    return sat(q);
  endfunction

  task automatic step(input logic lx, it, ie, lt, le, i0, cu, sx);
    int nx, nt, ne, nc;
    {ldX, initT1, initE1, ldT, ldE, init0, cntUp, selXR} = {lx, it, ie, lt, le, i0, cu, sx};
    nx = lx ? int'(xBus) : mx;
    nt = it ? 4096 : lt ? fmul(mt, sx ? mx : rom[mc]) : mt;
    ne = ie ? 4096 : le ? sat(longint'(me) + longint'(mt)) : me;
    nc = i0 ? 0 : cu ? (mc + 1) % 8 : mc;
    @(posedge clk);
    #1;
    mx = nx; mt = nt; me = ne; mc = nc;
    {ldX, initT1, initE1, ldT, ldE, init0, cntUp, selXR} = '0;
  endtask

  task automatic getinput(input int x);
    xBus = 16'(x);
    step(1, 1, 1, 0, 0, 1, 0, 0);
  endtask
  task automatic mult1(); step(0, 0, 0, 1, 0, 0, 0, 1); endtask
  task automatic mult2(); step(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic add();   step(0, 0, 0, 0, 1, 0, 1, 0); endtask

  task automatic run_exp(input int x);
    getinput(x);
    for (int i = 0; i < 8; i++) begin
      mult1(); mult2(); add();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mx = 0; mt = 0; me = 0; mc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 16'sd0 || cnt8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_during result=%0d cnt8=%b expected 0/0", result, cnt8);
    end
    do_reset();
    checks++;
    if (result !== 16'sd0 || cnt8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_after result=%0d cnt8=%b expected 0/0", result, cnt8);
    end
  endtask

  task automatic test_zero();
    getinput(0);
    for (int i = 0; i < 8; i++) begin
      mult1(); mult2();
      checks++;
      if (cnt8 !== (i == 7)) begin
        failures++;
        $display("FAIL zero_cnt8 iter=%0d got=%b expected=%b", i, cnt8, i == 7);
      end
      add();
    end
    checks++;
    if (result !== 16'sd4096) begin
      failures++;
      $display("FAIL zero_result got=%0d expected=4096", result);
    end
    checks++;
    if (cnt8 !== 1'b0) begin
      failures++;
      $display("FAIL zero_wrap cnt8=%b expected 0", cnt8);
    end
  endtask

  task automatic test_known(input string name, input int x, input int target);
    int d;
    run_exp(x);
    d = int'(result) - target;
    checks++;
    if (int'(result) !== me) begin
      failures++;
      $display("FAIL %s_model got=%0d expected=%0d", name, result, me);
    end
    checks++;
    if (d > 16 || d < -16) begin
      failures++;
      $display("FAIL %s_tol got=%0d expected=%0d+/-16", name, result, target);
    end
  endtask

  task automatic test_saturate();
    bit neg_seen = 0;
    getinput(12288);
    for (int i = 0; i < 8; i++) begin
      mult1(); mult2(); add();
      if (result < 0) neg_seen = 1;
    end
    checks++;
    if (result !== 16'sd32767 || neg_seen) begin
      failures++;
      $display("FAIL sat_result got=%0d neg_seen=%0d expected=32767", result, neg_seen);
    end
    checks++;
    if (int'(result) !== me) begin
      failures++;
      $display("FAIL sat_model got=%0d expected=%0d", result, me);
    end
  endtask

  task automatic test_rst_mid();
    getinput(4096);
    for (int i = 0; i < 3; i++) begin
      mult1(); mult2(); add();
    end
    mult1();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (result !== 16'sd0 || cnt8 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async result=%0d cnt8=%b expected 0/0", result, cnt8);
    end
    mx = 0; mt = 0; me = 0; mc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (result !== 16'sd0) begin
      failures++;
      $display("FAIL rst_mid_t got=%0d expected=0", result);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (result !== 16'sd0) begin
      failures++;
      $display("FAIL rst_mid_x got=%0d expected=0", result);
    end
    test_known("rst_mid_rerun", 4096, 11134);
  endtask

  task automatic test_priority();
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (cnt8 !== (k == 7)) begin
        failures++;
        $display("FAIL prio_cnt pulse=%0d cnt8=%b expected=%b", k, cnt8, k == 7);
      end
    end
    xBus = 16'sd8192;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (result !== 16'sd4096) begin
      failures++;
      $display("FAIL prio_t got=%0d expected=4096", result);
    end
    step(0, 0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (result !== 16'sd4096) begin
      failures++;
      $display("FAIL prio_e got=%0d expected=4096", result);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    for (int n = 0; n < 4; n++) begin
      do_reset();
      a = int'($urandom_range(65535)) - 32768;
      xBus = 16'(a);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      xBus = 16'($urandom);
      step(1, 0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (int'(result) !== a) begin
        failures++;
        $display("FAIL b2b_oldx got=%0d expected=%0d", result, a);
      end
    end
  endtask

  task automatic test_random_exp();
    int x;
    for (int n = 0; n < 6; n++) begin
      x = int'($urandom_range(16384)) - 8192;
      run_exp(x);
      checks++;
      if (int'(result) !== me) begin
        failures++;
        $display("FAIL rand_exp x=%0d got=%0d expected=%0d", x, result, me);
      end
    end
  endtask

  task automatic test_random_ctrl();
    logic [7:0] c;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      c = 8'($urandom);
      xBus = 16'($urandom);
      step(c[7], c[6], c[5], c[4], c[3], c[2] & c[1], c[1], c[0]);
      checks++;
      if (int'(result) !== me || cnt8 !== (mc == 7)) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d result=%0d cnt8=%b expected=%0d/%b", n, result, cnt8, me, mc == 7);
      end
    end
  endtask

  initial begin
    {ldX, initT1, initE1, ldT, ldE, init0, cntUp, selXR} = '0;
    xBus = '0;
    test_reset();
    test_zero();
    test_known("one", 4096, 11134);
    test_known("neg_one", -4096, 1507);
    test_saturate();
    test_rst_mid();
    test_priority();
    test_back_to_back();
    test_random_exp();
    test_random_ctrl();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
